// File: rtl/i2s_pkg.sv
// Constants shared by the I2S transmit and receive paths.
package i2s_pkg;

  localparam int DEF_DATA_W  = 24;
  localparam int DEF_CLK_DIV = 8;

  // Philips frame: two 32-bit slots, MSB one bit after the WS edge.
  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;
  localparam int SLOT_IDX_W = $clog2(SLOT_BITS);
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);

  // Word-select encoding on the wire.
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sck_gen.sv
// Serial bit clock generator: divides clk into a registered SCK and flags the
// cycle in which SCK is about to rise or fall, so users stay in the clk domain.
module i2s_sck_gen
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV  // clk cycles per SCK half-period, >= 2
) (
  input  logic clk,
  input  logic Reset,
  output logic sck,
  output logic fall_stb,
  output logic rise_stb
);

  localparam int DIV_W = ($clog2(CLK_DIV) > 0) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sck_q, sck_d;
  logic             term;

  assign term = (div_q == DIV_LAST);

  // Divider wraps at terminal count and SCK toggles on the wrap.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    sck_d = sck_q;
    if (term) begin
      div_d = '0;
      sck_d = ~sck_q;
    end
  end

  // Divider and SCK registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  // Strobes are high in the cycle before SCK changes, so logic updated on a
  // strobe changes together with SCK.
  assign sck      = sck_q;
  assign fall_stb = term & sck_q;
  assign rise_stb = term & ~sck_q;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding register behind a valid/ready port, a
// shift pair reloaded once per frame, and Philips-format serialisation.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,  // >= 2
  parameter int DATA_W  = DEF_DATA_W    // <= 31
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] L_Data,
  input  logic [DATA_W-1:0] R_Data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dac_sck,
  output logic              dac_ws,
  output logic              dac_sd,
  output logic              underrun
);

  // Handshake: a pair transfers in any cycle where in_valid and in_ready are
  // both high at the rising edge; in_ready does not depend on in_valid, and a
  // source must hold its pair stable until it transfers.

  logic                 fall_stb, rise_stb;
  logic [BIT_CNT_W-1:0] bit_q, bit_d, bit_nxt;
  logic                 ws_q, ws_d, sd_q, sd_d, und_q, und_d;
  logic                 hold_full_q, hold_full_d;
  logic [DATA_W-1:0]    hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic [DATA_W-1:0]    shl_q, shl_d, shr_q, shr_d;
  logic [DATA_W-1:0]    word_sel;
  logic [SLOT_BITS-1:0] slot_w;
  logic [SLOT_IDX_W-1:0] slot_pos;
  logic                 transfer, load;

  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk      (clk),
    .Reset    (Reset),
    .sck      (dac_sck),
    .fall_stb (fall_stb),
    .rise_stb (rise_stb)
  );

  assign in_ready = !hold_full_q && !Reset;
  assign transfer = in_valid && in_ready;
  // The fall that wraps the bit counter starts a new frame.
  assign load     = fall_stb && (bit_q == BIT_CNT_W'(FRAME_BITS - 1));

  // Bit counter, WS/SD serialiser and hold/shift register movement.
  always_comb begin
    bit_nxt  = bit_q + BIT_CNT_W'(1);
    word_sel = bit_nxt[BIT_CNT_W-1] ? shr_q : shl_q;
    // Slot image: bit 31 is the delay bit, then the sample MSB-first, then
    // zero padding; slot position b maps to slot_w[31-b].
    slot_w   = SLOT_BITS'(word_sel) << (SLOT_BITS - 1 - DATA_W);
    slot_pos = ~bit_nxt[SLOT_IDX_W-1:0];

    bit_d       = bit_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    und_d       = 1'b0;
    hold_full_d = hold_full_q;
    hold_l_d    = hold_l_q;
    hold_r_d    = hold_r_q;
    shl_d       = shl_q;
    shr_d       = shr_q;

    if (fall_stb) begin
      bit_d = bit_nxt;
      ws_d  = bit_nxt[BIT_CNT_W-1] ? WS_RIGHT : WS_LEFT;
      sd_d  = slot_w[slot_pos];
    end

    // Slot position 0 always sends the delay bit, so the reload can land on
    // the same edge as the first serialised bit of the new frame.
    if (load) begin
      if (hold_full_q) begin
        shl_d       = hold_l_q;
        shr_d       = hold_r_q;
        hold_full_d = 1'b0;
      end else begin
        shl_d = '0;
        shr_d = '0;
        und_d = 1'b1;
      end
    end

    // A transfer on a load edge fills hold after the hold pair has moved on.
    if (transfer) begin
      hold_l_d    = L_Data;
      hold_r_d    = R_Data;
      hold_full_d = 1'b1;
    end
  end

  // State registers; reset discards any partially sent frame and held pair.
  always_ff @(posedge clk) begin
    if (Reset) begin
      bit_q       <= '0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      und_q       <= 1'b0;
      hold_full_q <= 1'b0;
      hold_l_q    <= '0;
      hold_r_q    <= '0;
      shl_q       <= '0;
      shr_q       <= '0;
    end else begin
      bit_q       <= bit_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      und_q       <= und_d;
      hold_full_q <= hold_full_d;
      hold_l_q    <= hold_l_d;
      hold_r_q    <= hold_r_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
    end
  end

  assign dac_ws   = ws_q;
  assign dac_sd   = sd_q;
  assign underrun = und_q;

  // The receiver samples on SCK rise: WS and SD must not move across it.
  a_stable_at_rise : assert property (@(posedge clk)
    (rise_stb && !Reset) |=> ($stable(sd_q) && $stable(ws_q)));

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: directed scenarios drive pairs, a serial-link monitor
// decodes frames on SCK rises and scores them against an expected queue.
module tb_i2s_tx;

  localparam int CLK_DIV   = 2;
  localparam int DATA_W    = 24;
  localparam int FRAME_CLK = 128 * CLK_DIV;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic Reset = 1'b1;
  logic [DATA_W-1:0] L_Data = '0;
  logic [DATA_W-1:0] R_Data = '0;
  logic in_valid = 1'b0;
  logic in_ready, dac_sck, dac_ws, dac_sd, underrun;

  always #5 clk = ~clk;

  i2s_tx #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .Reset    (Reset),
    .L_Data   (L_Data),
    .R_Data   (R_Data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .dac_sck  (dac_sck),
    .dac_ws   (dac_ws),
    .dac_sd   (dac_sd),
    .underrun (underrun)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rel0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard state ----------------
  logic [2*DATA_W-1:0] exp_q[$];
  int acc_cyc[$];
  int und_falls[$];
  logic [63:0] frame_log[$];
  int load_cyc[0:15];
  int fall_cnt, nbits;
  logic sck_p, ws_p, sd_p, ws_rise_p, cur_zero, und_seen;
  logic [63:0] shreg;

  // Stimulus side: every accepted pair becomes an expected frame.
  always @(negedge clk) begin
    if (!Reset && in_valid && in_ready) begin
      exp_q.push_back({L_Data, R_Data});
      acc_cyc.push_back(cyc);
    end
  end

  // Link monitor: fall bookkeeping, WS/SD stability, frame decode and scoring.
  always @(negedge clk) begin
    logic fell, rose;
    logic [2*DATA_W-1:0] e;
    if (Reset) begin
      fall_cnt = 0; nbits = 0; shreg = '0;
      sck_p = 0; ws_p = 0; sd_p = 0; ws_rise_p = 0;
      cur_zero = 1; und_seen = 0;
      exp_q.delete(); und_falls.delete(); frame_log.delete();
      foreach (load_cyc[i]) load_cyc[i] = -1;
    end else begin
      fell = sck_p && !dac_sck;
      rose = !sck_p && dac_sck;
      if (fell) begin
        fall_cnt++;
        check("ws_at_fall", dac_ws, (fall_cnt % 64) >= 32);
        if (fall_cnt % 64 == 0 && fall_cnt / 64 < 16) load_cyc[fall_cnt / 64] = cyc;
      end else begin
        check("ws_sd_stable", {dac_ws, dac_sd}, {ws_p, sd_p});
      end
      if (underrun) begin
        und_falls.push_back(fall_cnt);
        und_seen = 1;
        check("underrun_on_load", {fell, fall_cnt % 64 == 0}, 2'b11);
      end
      if (rose) begin
        if (ws_rise_p && !dac_ws) begin
          check("frame_len", nbits, 64);
          frame_log.push_back(shreg);
          if (cur_zero) begin
            check("zero_frame", shreg, 64'h0);
          end else if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_exp: frame %h arrived with no pair expected", shreg);
          end else begin
            e = exp_q.pop_front();
            check("frame_data", shreg,
                  {1'b0, e[2*DATA_W-1:DATA_W], 7'b0, 1'b0, e[DATA_W-1:0], 7'b0});
          end
          cur_zero = und_seen;
          und_seen = 0;
          shreg = '0;
          nbits = 0;
        end
        shreg = {shreg[62:0], dac_sd};
        nbits++;
        ws_rise_p = dac_ws;
      end
      sck_p = dac_sck; ws_p = dac_ws; sd_p = dac_sd;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    @(posedge clk);
    #1 Reset = 1'b1;
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1 Reset = 1'b0;
    acc_cyc.delete();
    rel0 = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    int waited;
    L_Data = l;
    R_Data = r;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 4 * FRAME_CLK) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, waited);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    logic [DATA_W-1:0] rl, rr;

    // Reset mid-frame while a pair is being sent, in_valid held high.
    do_reset(3);
    send_pair(24'h123456, 24'h654321);
    idle(420);
    Reset = 1'b1;
    in_valid = 1'b1;
    L_Data = 24'hFFFFFF;
    R_Data = 24'hFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("outputs_in_reset", {dac_sck, dac_ws, dac_sd, underrun, in_ready}, 5'b0);
    end
    @(posedge clk);
    #1 Reset = 1'b0;
    in_valid = 1'b0;
    acc_cyc.delete();
    for (int n = 0; n <= CLK_DIV; n++) begin
      @(negedge clk);
      check("sck_after_release", dac_sck, n >= CLK_DIV);
      if (n == 0) check("ready_after_release", in_ready, 1'b1);
    end

    // Single pair accepted at clk 1: frame 2 carries it, frame 3 underruns.
    do_reset(3);
    idle(1);
    send_pair(24'hA5A5A5, 24'h5A5A5A);
    if (acc_cyc.size() > 0) check("single_accept_cyc", acc_cyc[0], rel0 + 1);
    idle(800);
    check("single_frames_seen", frame_log.size() >= 3, 1'b1);
    if (frame_log.size() >= 3) begin
      check("single_frame1", frame_log[0], 64'h0);
      check("single_frame2", frame_log[1], 64'h52D2D280_2D2D2D00);
      check("single_frame3", frame_log[2], 64'h0);
    end
    check("single_und_count", und_falls.size(), 2);
    if (und_falls.size() >= 2) begin
      check("single_und_fall0", und_falls[0], 128);
      check("single_und_fall1", und_falls[1], 192);
    end

    // Backpressure: three pairs back-to-back.
    do_reset(3);
    send_pair(24'h800001, 24'h7FFFFE);
    send_pair(24'hFFFFFF, 24'h000001);
    send_pair(24'h3C3C3C, 24'hC3C3C3);
    check("bp_accepts", acc_cyc.size(), 3);
    check("bp_first_fall64_cyc", load_cyc[1], rel0 + 2 * CLK_DIV * 64);
    if (acc_cyc.size() == 3) begin
      check("bp_accept0", acc_cyc[0], rel0);
      check("bp_accept1", acc_cyc[1], load_cyc[1]);
      check("bp_accept2", acc_cyc[2], load_cyc[2]);
    end
    idle(530);
    check("bp_und_count", und_falls.size(), 1);
    if (und_falls.size() > 0) check("bp_und_fall", und_falls[0], 256);
    check("bp_exp_drained", exp_q.size(), 0);

    // Pair offered on the load cycle with nothing held.
    do_reset(3);
    idle(2 * CLK_DIV * 64 - 1);
    L_Data = 24'h00F00F;
    R_Data = 24'hF00F00;
    in_valid = 1'b1;
    @(negedge clk);
    check("sim_ready_on_load", {in_ready, dac_sck}, 2'b11);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("sim_underrun", {underrun, dac_sck}, 2'b10);
    idle(1);
    if (acc_cyc.size() > 0) check("sim_accept_cyc", acc_cyc[0], load_cyc[1] - 1);
    idle(520);
    check("sim_exp_drained", exp_q.size(), 0);
    check("sim_und_count", und_falls.size(), 2);
    if (und_falls.size() >= 2) begin
      check("sim_und_fall0", und_falls[0], 64);
      check("sim_und_fall1", und_falls[1], 192);
    end

    // Loopback of 100 random pairs through the frame decoder.
    do_reset(3);
    for (int i = 0; i < 100; i++) begin
      rl = DATA_W'($urandom_range(1, 32'hFFFFFF));
      rr = DATA_W'($urandom_range(1, 32'hFFFFFF));
      send_pair(rl, rr);
    end
    check("loop_no_underrun", und_falls.size(), 0);
    idle(3 * FRAME_CLK);
    check("loop_exp_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog in case a scenario stalls.
  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
